// File: rtl/hw_mtimer_pkg.sv
// rtl/hw_mtimer_pkg.sv - register offsets, CTRL fields, reset values and byte-merge helper for hw_mtimer
package hw_mtimer_pkg;

  localparam logic [4:0] OFF_MTIME_LO    = 5'h00;
  localparam logic [4:0] OFF_MTIME_HI    = 5'h04;
  localparam logic [4:0] OFF_MTIMECMP_LO = 5'h08;
  localparam logic [4:0] OFF_MTIMECMP_HI = 5'h0C;
  localparam logic [4:0] OFF_CTRL        = 5'h10;

  localparam int CTRL_EN_BIT  = 0;
  localparam int CTRL_DIV_LSB = 8;
  localparam int CTRL_DIV_W   = 8;

  localparam logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_ACK  = 1'b1;

  // Replace only the bytes selected by be; the rest keep old_v.
  function automatic logic [31:0] byte_merge(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  be);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) begin
      r[8*i +: 8] = be[i] ? new_v[8*i +: 8] : old_v[8*i +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/hw_mtimer_cnt.sv
// rtl/hw_mtimer_cnt.sv - prescaler, 64-bit mtime counter and byte-masked store merge
module hw_mtimer_cnt
  import hw_mtimer_pkg::*;
(
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_en,
  input  logic [CTRL_DIV_W-1:0] i_div,
  input  logic                  i_clr_pcnt,
  input  logic                  i_wr_lo,
  input  logic                  i_wr_hi,
  input  logic [31:0]           i_wdata,
  input  logic [3:0]            i_be,
  output logic [63:0]           o_mtime
);

  logic [CTRL_DIV_W-1:0] r_pcnt;
  logic [63:0]           r_mtime;
  logic                  w_tick;
  logic [63:0]           w_inc;
  logic [63:0]           w_next;

  // Increment first, then let a store overwrite only its enabled bytes.
  always_comb begin
    w_tick = i_en && (r_pcnt == i_div);
    w_inc  = r_mtime + {63'd0, w_tick};
    w_next = w_inc;
    if (i_wr_lo) w_next[31:0]  = byte_merge(w_inc[31:0],  i_wdata, i_be);
    if (i_wr_hi) w_next[63:32] = byte_merge(w_inc[63:32], i_wdata, i_be);
  end

  // Prescaler: counts up to DIV then restarts; a CTRL store restarts it.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pcnt <= '0;
    end else if (i_clr_pcnt) begin
      r_pcnt <= '0;
    end else if (i_en) begin
      r_pcnt <= w_tick ? '0 : r_pcnt + 8'd1;
    end
  end

  // Counter register: full 64-bit wrap, store merge applied on top.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_mtime <= '0;
    end else begin
      r_mtime <= w_next;
    end
  end

  assign o_mtime = r_mtime;

endmodule

// File: rtl/hw_mtimer.sv
// rtl/hw_mtimer.sv - memory-mapped machine timer: bus FSM, decode, hi snapshot, compare/irq
module hw_mtimer
  import hw_mtimer_pkg::*;
#(
  parameter int OFFSET_W = 5
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                req_i,
  input  logic                we_i,
  input  logic [OFFSET_W-1:0] addr_i,
  input  logic [31:0]         wdata_i,
  input  logic [3:0]          be_i,
  output logic [31:0]         rdata_o,
  output logic                ack_o,
  output logic                err_o,
  output logic                irq_o
);

  logic [0:0]            r_state;
  logic [63:0]           r_mtimecmp;
  logic                  r_en;
  logic [CTRL_DIV_W-1:0] r_div;
  logic [31:0]           r_hi_shadow;
  logic [31:0]           r_rdata;
  logic                  r_ack;
  logic                  r_err;
  logic                  r_irq;

  logic [63:0] w_mtime;
  logic        w_fire;
  logic        w_ok;
  logic        w_wr;
  logic        w_rd;
  logic        w_sel_mlo;
  logic        w_sel_mhi;
  logic        w_sel_clo;
  logic        w_sel_chi;
  logic        w_sel_ctrl;
  logic [31:0] w_rd_mux;

  // Decode: only aligned word offsets up to CTRL are mapped.
  always_comb begin
    w_fire     = (r_state == ST_IDLE) && req_i;
    w_ok       = (addr_i[1:0] == 2'b00) && (addr_i <= OFFSET_W'(OFF_CTRL));
    w_wr       = w_fire && we_i && w_ok;
    w_rd       = w_fire && !we_i && w_ok;
    w_sel_mlo  = (addr_i == OFFSET_W'(OFF_MTIME_LO));
    w_sel_mhi  = (addr_i == OFFSET_W'(OFF_MTIME_HI));
    w_sel_clo  = (addr_i == OFFSET_W'(OFF_MTIMECMP_LO));
    w_sel_chi  = (addr_i == OFFSET_W'(OFF_MTIMECMP_HI));
    w_sel_ctrl = (addr_i == OFFSET_W'(OFF_CTRL));
  end

  // Load data: MTIME_HI reads the snapshot taken by the last MTIME_LO load.
  always_comb begin
    w_rd_mux = '0;
    if (w_sel_mlo)  w_rd_mux = w_mtime[31:0];
    if (w_sel_mhi)  w_rd_mux = r_hi_shadow;
    if (w_sel_clo)  w_rd_mux = r_mtimecmp[31:0];
    if (w_sel_chi)  w_rd_mux = r_mtimecmp[63:32];
    if (w_sel_ctrl) begin
      w_rd_mux[CTRL_EN_BIT]                 = r_en;
      w_rd_mux[CTRL_DIV_LSB +: CTRL_DIV_W]  = r_div;
    end
  end

  hw_mtimer_cnt u_cnt (
    .i_clk      (clk_i),
    .i_rst_n    (rst_i),
    .i_en       (r_en),
    .i_div      (r_div),
    .i_clr_pcnt (w_wr && w_sel_ctrl),
    .i_wr_lo    (w_wr && w_sel_mlo),
    .i_wr_hi    (w_wr && w_sel_mhi),
    .i_wdata    (wdata_i),
    .i_be       (be_i),
    .o_mtime    (w_mtime)
  );

  // Two-state responder: accept in IDLE, always return after one ACK cycle.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state <= ST_IDLE;
    end else if (r_state == ST_IDLE) begin
      if (req_i) r_state <= ST_ACK;
    end else begin
      r_state <= ST_IDLE;
    end
  end

  // Response registers: one-cycle ack, error flag, load data zero otherwise.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_ack   <= 1'b0;
      r_err   <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_ack   <= w_fire;
      r_err   <= w_fire && !w_ok;
      r_rdata <= w_rd ? w_rd_mux : 32'd0;
    end
  end

  // Capture the live high word whenever the low word is loaded.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_hi_shadow <= '0;
    end else if (w_rd && w_sel_mlo) begin
      r_hi_shadow <= w_mtime[63:32];
    end
  end

  // Compare register and CTRL byte-masked stores.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_mtimecmp <= MTIMECMP_RST;
      r_en       <= 1'b0;
      r_div      <= '0;
    end else if (w_wr) begin
      if (w_sel_clo) r_mtimecmp[31:0]  <= byte_merge(r_mtimecmp[31:0],  wdata_i, be_i);
      if (w_sel_chi) r_mtimecmp[63:32] <= byte_merge(r_mtimecmp[63:32], wdata_i, be_i);
      if (w_sel_ctrl) begin
        if (be_i[CTRL_EN_BIT / 8])  r_en  <= wdata_i[CTRL_EN_BIT];
        if (be_i[CTRL_DIV_LSB / 8]) r_div <= wdata_i[CTRL_DIV_LSB +: CTRL_DIV_W];
      end
    end
  end

  // Registered interrupt level, independent of EN.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_irq <= 1'b0;
    end else begin
      r_irq <= (w_mtime >= r_mtimecmp);
    end
  end

  assign rdata_o = r_rdata;
  assign ack_o   = r_ack;
  assign err_o   = r_err;
  assign irq_o   = r_irq;

endmodule

// File: tb/tb_hw_mtimer.sv
// tb/tb_hw_mtimer.sv - scoreboard bench for hw_mtimer
module tb_hw_mtimer;

  logic        clk;
  logic        rst_n;
  logic        req;
  logic        we;
  logic [4:0]  addr;
  logic [31:0] wdata;
  logic [3:0]  be;
  logic [31:0] rdata;
  logic        ack;
  logic        err;
  logic        irq;

  int total = 0;
  int bad   = 0;
  logic irq_at_commit;

  typedef struct {
    logic [31:0] lo;
    logic [31:0] hi;
    logic        err;
    string       name;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  hw_mtimer #(.OFFSET_W(5)) dut (
    .clk_i   (clk),
    .rst_i   (rst_n),
    .req_i   (req),
    .we_i    (we),
    .addr_i  (addr),
    .wdata_i (wdata),
    .be_i    (be),
    .rdata_o (rdata),
    .ack_o   (ack),
    .err_o   (err),
    .irq_o   (irq)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  // Monitor: every ack consumes one scoreboard entry.
  always @(negedge clk) begin
    if (ack === 1'b1) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL unexpected_ack act=rdata:%08h err:%0b exp=no_ack", rdata, err);
      end else begin
        mon_e = sb.pop_front();
        if ($isunknown(rdata) || err !== mon_e.err || rdata < mon_e.lo || rdata > mon_e.hi) begin
          bad++;
          $display("FAIL %s act=rdata:%08h err:%0b exp=rdata:[%08h..%08h] err:%0b",
                   mon_e.name, rdata, err, mon_e.lo, mon_e.hi, mon_e.err);
        end
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  task automatic access(input logic w, input logic [4:0] a, input logic [31:0] d,
                        input logic [3:0] b, input logic [31:0] lo, input logic [31:0] hi,
                        input logic e, input string name);
    exp_t x;
    x.lo = lo; x.hi = hi; x.err = e; x.name = name;
    sb.push_back(x);
    @(posedge clk); #1;
    req = 1'b1; we = w; addr = a; wdata = d; be = b;
    @(posedge clk); #1;
    irq_at_commit = irq;
    req = 1'b0; we = 1'b0; addr = '0; wdata = '0; be = '0;
    @(posedge clk);
  endtask

  task automatic load(input logic [4:0] a, input logic [31:0] lo, input logic [31:0] hi,
                      input string name);
    access(1'b0, a, 32'd0, 4'h0, lo, hi, 1'b0, name);
  endtask

  task automatic store(input logic [4:0] a, input logic [31:0] d, input logic [3:0] b,
                       input string name);
    access(1'b1, a, d, b, 32'd0, 32'd0, 1'b0, name);
  endtask

  initial begin
    rst_n = 1'b0; req = 1'b0; we = 1'b0; addr = '0; wdata = '0; be = '0;
    irq_at_commit = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ack", ack, 0);
    check("rst_err", err, 0);
    check("rst_rdata", rdata, 0);
    check("rst_irq", irq, 0);
    rst_n = 1'b1;

    // Reset values through the bus
    load(5'h08, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "rst_cmp_lo");
    load(5'h0C, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "rst_cmp_hi");
    load(5'h00, 32'd0, 32'd0, "rst_mtime_lo");
    load(5'h10, 32'd0, 32'd0, "rst_ctrl");
    #1 check("rst_irq_idle", irq, 0);

    // Prescaler DIV=3: ~40 cycles -> mtime about 10
    store(5'h10, 32'h0000_0301, 4'hF, "st_ctrl_div3");
    repeat (38) @(posedge clk);
    load(5'h00, 32'd9, 32'd11, "div3_count");
    load(5'h10, 32'h0000_0301, 32'h0000_0301, "ctrl_readback");
    store(5'h10, 32'h0000_0300, 4'hF, "st_ctrl_off");
    store(5'h00, 32'h0000_1234, 4'hF, "st_mtime_frozen");
    repeat (20) @(posedge clk);
    load(5'h00, 32'h0000_1234, 32'h0000_1234, "frozen_lo");
    load(5'h04, 32'd0, 32'd0, "frozen_hi");

    // Carry from LO into HI, coherent snapshot pair
    store(5'h00, 32'hFFFF_FFFF, 4'hF, "st_lo_ones");
    store(5'h04, 32'd0, 4'hF, "st_hi_zero");
    store(5'h10, 32'h0000_0001, 4'hF, "st_ctrl_div0");
    load(5'h00, 32'd0, 32'd2, "wrap_lo");
    load(5'h04, 32'd1, 32'd1, "wrap_hi_shadow");

    // Compare / irq timing
    store(5'h10, 32'd0, 4'hF, "st_ctrl_stop");
    store(5'h00, 32'd0, 4'hF, "st_lo_clr");
    store(5'h04, 32'd0, 4'hF, "st_hi_clr");
    store(5'h0C, 32'd0, 4'hF, "st_cmp_hi0");
    store(5'h08, 32'h20, 4'hF, "st_cmp_lo20");
    #1 check("irq_before_run", irq, 0);
    store(5'h10, 32'h0000_0001, 4'hF, "st_ctrl_run");
    repeat (31) @(posedge clk);
    #1 check("irq_at_mtime_20", irq, 0);
    @(posedge clk); #1 check("irq_rise", irq, 1);
    store(5'h0C, 32'd1, 4'hF, "st_cmp_hi1");
    check("irq_at_commit", irq_at_commit, 1);
    #1 check("irq_fall", irq, 0);

    // Byte enables and error accesses
    store(5'h08, 32'hAABB_CCDD, 4'b0010, "st_cmp_be");
    load(5'h08, 32'h0000_CC20, 32'h0000_CC20, "cmp_lo_be");
    load(5'h0C, 32'd1, 32'd1, "cmp_hi_be");
    access(1'b1, 5'h0A, 32'd0, 4'hF, 32'd0, 32'd0, 1'b1, "err_st_0a");
    access(1'b0, 5'h02, 32'd0, 4'h0, 32'd0, 32'd0, 1'b1, "err_ld_02");
    access(1'b0, 5'h14, 32'd0, 4'h0, 32'd0, 32'd0, 1'b1, "err_ld_14");
    access(1'b1, 5'h14, 32'hFFFF_FFFF, 4'hF, 32'd0, 32'd0, 1'b1, "err_st_14");
    load(5'h08, 32'h0000_CC20, 32'h0000_CC20, "cmp_lo_after_err");
    load(5'h10, 32'h0000_0001, 32'h0000_0001, "ctrl_after_err");

    // Asynchronous reset during the ACK cycle
    @(posedge clk); #1;
    req = 1'b1; we = 1'b1; addr = 5'h08; wdata = 32'h55; be = 4'hF;
    @(posedge clk); #1;
    req = 1'b0; we = 1'b0; addr = '0; wdata = '0; be = '0;
    check("rst_mid_ack_pre", ack, 1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_ack", ack, 0);
    check("rst_mid_err", err, 0);
    check("rst_mid_irq", irq, 0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    load(5'h08, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "post_rst_cmp_lo");
    load(5'h0C, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "post_rst_cmp_hi");
    load(5'h00, 32'd0, 32'd0, "post_rst_mtime");
    load(5'h04, 32'd0, 32'd0, "post_rst_shadow");
    load(5'h10, 32'd0, 32'd0, "post_rst_ctrl");
    #1 check("post_rst_irq", irq, 0);

    repeat (3) @(posedge clk);
    check("sb_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
